// File: rtl/tx_stream_arb_pkg.sv
// Shared definitions for the TX stream arbiter: FSM encoding and frame header layout.
// Host-side decoders and benches import this to locate header fields.
package tx_stream_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_PAD  = 2'd3
    } arb_state_e;

    localparam logic [7:0] HDR_MAGIC     = 8'hA5;
    localparam int         HDR_FIELD_W   = 8;
    localparam int         HDR_LEN_LSB   = 0;
    localparam int         HDR_SEQ_LSB   = 8;
    localparam int         HDR_ID_LSB    = 16;
    localparam int         HDR_MAGIC_LSB = 24;

endpackage

// File: rtl/tx_stream_arb_rr_pick.sv
// Combinational round-robin select: first request at or cyclically after ptr_i.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    // Scan N candidates starting at the pointer; the first hit wins.
    always_comb begin
        int   cand;
        logic hit;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand        = (int'(ptr_i) + k) % N;
            hit         = !any_o && req_i[cand];
            gnt_o[cand] = gnt_o[cand] | hit;
            idx_o       = hit ? PW'(cand) : idx_o;
            any_o       = any_o | hit;
        end
    end

endmodule

// File: rtl/tx_stream_arb.sv
// Frames beats from N_SRC source streams into one TX stream: header, payload
// pass-through from the granted source, and filler beats if the source stalls.
module tx_stream_arb
    import tx_stream_arb_pkg::*;
#(
    parameter int             N_SRC       = 4,
    parameter int             W           = 32,
    parameter int             FRAME_BEATS = 8,
    parameter int             PAD_TIMEOUT = 64,
    parameter logic [W-1:0]   PAD_WORD    = {W{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SRC-1:0]     cfg_en,
    input  logic [N_SRC-1:0]     s_val,
    output logic [N_SRC-1:0]     s_rdy,
    input  logic [N_SRC*W-1:0]   s_data,
    output logic                 o_val,
    input  logic                 o_rdy,
    output logic [W-1:0]         o_data,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int BW = $clog2(FRAME_BEATS);
    localparam int IW = (PAD_TIMEOUT > 0) ? $clog2(PAD_TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] LAST_CNT = BW'(FRAME_BEATS - 2);
    localparam logic [IW-1:0] IDLE_MAX = IW'(PAD_TIMEOUT);

    arb_state_e           state_q, state_d;
    logic [PW-1:0]        grant_q, grant_d;
    logic [N_SRC-1:0]     grant_oh_q, grant_oh_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic [7:0]           seq_q [N_SRC];
    logic                 frame_end_s;
    logic [N_SRC-1:0]     req_s;
    logic [N_SRC-1:0]     pick_oh_s;
    logic [PW-1:0]        pick_idx_s;
    logic                 pick_any_s;
    logic [W-1:0]         hdr_s;
    logic [W-1:0]         src_data_s;

    assign req_s      = s_val & cfg_en;
    assign src_data_s = s_data[grant_q*W +: W];
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_end_s;

    rr_pick #(
        .N  (N_SRC),
        .PW (PW)
    ) u_rr_pick (
        .req_i (req_s),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_oh_s),
        .idx_o (pick_idx_s),
        .any_o (pick_any_s)
    );

    // Header beat for the currently granted source.
    always_comb begin
        hdr_s = '0;
        hdr_s[HDR_MAGIC_LSB +: HDR_FIELD_W] = HDR_MAGIC;
        hdr_s[HDR_ID_LSB    +: HDR_FIELD_W] = 8'(grant_q);
        hdr_s[HDR_SEQ_LSB   +: HDR_FIELD_W] = seq_q[grant_q];
        hdr_s[HDR_LEN_LSB   +: HDR_FIELD_W] = 8'(FRAME_BEATS - 1);
    end

    // Next-state and stream outputs; beat_cnt counts beats after the header.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_oh_d  = grant_oh_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        frame_end_s = 1'b0;
        o_val       = 1'b0;
        o_data      = '0;
        s_rdy       = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_any_s) begin
                    grant_d    = pick_idx_s;
                    grant_oh_d = pick_oh_s;
                    state_d    = S_HDR;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_HDR: begin
                o_val  = 1'b1;
                o_data = hdr_s;
                if (o_rdy) begin
                    state_d    = S_DATA;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end else begin
                    state_d    = S_HDR;
                end
            end
            S_DATA: begin
                o_val  = s_val[grant_q];
                o_data = src_data_s;
                s_rdy  = grant_oh_q & {N_SRC{o_rdy}};
                if (s_val[grant_q]) begin
                    idle_cnt_d = '0;
                    if (o_rdy && (beat_cnt_q == LAST_CNT)) begin
                        frame_end_s = 1'b1;
                    end else if (o_rdy) begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end else begin
                        beat_cnt_d = beat_cnt_q;
                    end
                end else if ((PAD_TIMEOUT > 0) && (idle_cnt_q == IDLE_MAX - IW'(1))) begin
                    idle_cnt_d = IDLE_MAX;
                    state_d    = S_PAD;
                end else if (PAD_TIMEOUT > 0) begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end else begin
                    idle_cnt_d = idle_cnt_q;
                end
            end
            S_PAD: begin
                // Sources are held off entirely; the frame is completed with filler.
                o_val  = 1'b1;
                o_data = PAD_WORD;
                if (o_rdy && (beat_cnt_q == LAST_CNT)) begin
                    frame_end_s = 1'b1;
                end else if (o_rdy) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (frame_end_s) begin
            state_d  = S_IDLE;
            rr_ptr_d = (grant_q == PW'(N_SRC - 1)) ? '0 : grant_q + PW'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Per-source frame sequence numbers, wrapping modulo 256.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                seq_q[i] <= 8'd0;
            end
        end else if (frame_end_s) begin
            seq_q[grant_q] <= seq_q[grant_q] + 8'd1;
        end else begin
            seq_q[grant_q] <= seq_q[grant_q];
        end
    end

endmodule

// File: tb/tb_tx_stream_arb.sv
// Randomized bench for tx_stream_arb with a frame-level reference model.
module tb_tx_stream_arb;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int FB = 8;
    localparam int PT = 64;
    localparam logic [W-1:0] PADW = {W{1'b1}};
    localparam int BIG = 32'h3fffffff;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   cfg_en = '0;
    logic [N-1:0]   s_val = '0;
    logic [N-1:0]   s_rdy;
    logic [N*W-1:0] s_data = '0;
    logic           o_val;
    logic           o_rdy = 1'b0;
    logic [W-1:0]   o_data;
    logic           busy;
    logic           frame_done;

    always #5 clk = ~clk;

    tx_stream_arb #(
        .N_SRC       (N),
        .W           (W),
        .FRAME_BEATS (FB),
        .PAD_TIMEOUT (PT),
        .PAD_WORD    (PADW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_en     (cfg_en),
        .s_val      (s_val),
        .s_rdy      (s_rdy),
        .s_data     (s_data),
        .o_val      (o_val),
        .o_rdy      (o_rdy),
        .o_data     (o_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;

    // stimulus policy
    int       prob [N];
    int       lim  [N];
    int       rdy_prob;
    logic [N-1:0] en_pol;

    // source and reference model state
    int       sent [N];
    int       mcnt [N];
    int       seq  [N];
    bit       in_frame;
    bit       pad;
    int       g, pos, idle_run, gap, pad_beats, rr, frames;
    logic [31:0] hdr_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word(input int i, input int c);
        return {8'(i), 24'(c)};
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        in_frame = 1'b0;
        pad      = 1'b0;
        rr       = 0;
        frames   = 0;
        pos      = 0;
        hdr_q.delete();
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            mcnt[i] = sent[i];
        end
    endtask

    task automatic check_cycle();
        logic [N-1:0] req, exp_rdy;
        logic [W-1:0] exp_d;
        logic         exp_v, hs;
        int           ng;
        bit           start;
        req   = s_val & cfg_en;
        start = 1'b0;
        ng    = 0;
        if (!in_frame) begin
            chk("idle_o_val", o_val, 1'b0);
            chk("idle_s_rdy", s_rdy, 4'h0);
            chk("idle_busy", busy, 1'b0);
            chk("idle_frame_done", frame_done, 1'b0);
            if (req != '0) begin
                ng    = pick(req, rr);
                start = 1'b1;
            end
        end else begin
            exp_rdy = '0;
            if (pos == 0) begin
                exp_v = 1'b1;
                exp_d = {8'hA5, 8'(g), 8'(seq[g]), 8'(FB - 1)};
            end else if (pad) begin
                exp_v = 1'b1;
                exp_d = PADW;
            end else begin
                exp_v      = s_val[g];
                exp_d      = word(g, mcnt[g]);
                exp_rdy[g] = o_rdy;
            end
            chk("busy", busy, 1'b1);
            chk("o_val", o_val, exp_v);
            chk("s_rdy", s_rdy, exp_rdy);
            if (exp_v) chk("o_data", o_data, exp_d);
            if (!o_val) gap++;
            hs = exp_v && o_rdy;
            chk("frame_done", frame_done, hs && (pos == FB - 1));
            if (pos > 0 && !pad) begin
                if (!s_val[g]) begin
                    idle_run++;
                    if (idle_run == PT) pad = 1'b1;
                end else begin
                    idle_run = 0;
                end
            end
            if (hs) begin
                if (pos == 0) hdr_q.push_back(exp_d);
                else if (pad) pad_beats++;
                else mcnt[g]++;
                pos++;
                if (pos == FB) begin
                    seq[g]   = (seq[g] + 1) % 256;
                    rr       = (g + 1) % N;
                    in_frame = 1'b0;
                    frames++;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (s_val[i] && s_rdy[i]) sent[i]++;
        end
        if (start) begin
            in_frame  = 1'b1;
            g         = ng;
            pos       = 0;
            pad       = 1'b0;
            idle_run  = 0;
            gap       = 0;
            pad_beats = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cfg_en = en_pol;
        for (int i = 0; i < N; i++) begin
            s_val[i] = (sent[i] < lim[i]) && ($urandom_range(99) < prob[i]);
            s_data[i*W +: W] = word(i, sent[i]);
        end
        o_rdy = ($urandom_range(99) < rdy_prob);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        s_val = '0;
        o_rdy = 1'b0;
        #1;
        chk("rst_o_val", o_val, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_s_rdy", s_rdy, 4'h0);
        chk("rst_frame_done", frame_done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        for (int t = 0; t < budget && frames < n; t++) step();
        chk(tag, frames >= n, 1'b1);
    endtask

    task automatic wait_hdrs(input string tag, input int n, input int budget);
        for (int t = 0; t < budget && hdr_q.size() < n; t++) step();
        chk(tag, hdr_q.size() >= n, 1'b1);
    endtask

    task automatic set_probs(input int p0, input int p1, input int p2, input int p3);
        prob[0] = p0; prob[1] = p1; prob[2] = p2; prob[3] = p3;
    endtask

    initial begin
        int exp_ids [5] = '{0, 1, 2, 3, 0};
        int exp_seq [5] = '{0, 0, 0, 0, 1};
        int n0;
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            lim[i]  = BIG;
        end
        en_pol   = '1;
        rdy_prob = 100;
        set_probs(0, 0, 0, 0);
        do_reset();

        // single source, steady flow
        set_probs(0, 0, 100, 0);
        wait_frames("src2_frames_timeout", 2, 60);
        if (hdr_q.size() >= 2) begin
            chk("src2_hdr0", hdr_q[0], 32'hA5020007);
            chk("src2_hdr1", hdr_q[1], 32'hA5020107);
        end

        // all sources continuously valid
        do_reset();
        set_probs(100, 100, 100, 100);
        wait_hdrs("rr_hdrs_timeout", 5, 120);
        for (int k = 0; k < 5 && k < hdr_q.size(); k++) begin
            chk("rr_order_id", hdr_q[k][23:16], 8'(exp_ids[k]));
            chk("rr_order_seq", hdr_q[k][15:8], 8'(exp_seq[k]));
        end

        // source stalls after 3 payload beats: timeout then filler
        do_reset();
        set_probs(0, 100, 0, 0);
        lim[1] = sent[1] + 3;
        wait_frames("pad_frame_timeout", 1, 200);
        chk("pad_beats", pad_beats, 4);
        chk("pad_idle_gap", gap, PT);
        lim[1] = BIG;

        // enable withdrawn mid-frame
        do_reset();
        set_probs(100, 100, 0, 0);
        for (int t = 0; t < 40 && !(in_frame && g == 0 && pos == 3); t++) step();
        chk("cfg_mid_frame_reached", in_frame && g == 0 && pos == 3, 1'b1);
        en_pol[0] = 1'b0;
        wait_frames("cfg_frames_timeout", 4, 200);
        n0 = 0;
        foreach (hdr_q[k]) if (hdr_q[k][23:16] == 8'd0) n0++;
        chk("cfg_src0_grants", n0, 1);
        en_pol = '1;

        // randomized traffic, backpressure and enable churn
        do_reset();
        set_probs(70, 60, 80, 3);
        rdy_prob = 50;
        for (int t = 0; t < 3000; t++) begin
            if (t % 100 == 99) en_pol = 4'($urandom_range(15));
            step();
        end
        chk("rand_frames_seen", frames > 20, 1'b1);

        // reset in the middle of a frame
        en_pol   = '1;
        rdy_prob = 100;
        do_reset();
        set_probs(100, 100, 100, 100);
        for (int t = 0; t < 40 && !(in_frame && pos == 4); t++) step();
        chk("rst_mid_frame_reached", in_frame && pos == 4, 1'b1);
        do_reset();
        wait_hdrs("post_rst_hdr_timeout", 1, 20);
        if (hdr_q.size() >= 1) chk("post_rst_hdr", hdr_q[0], 32'hA5000007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
